// File: rtl/imul_pkg.sv
// Shared types and constants for the iterative 32-bit multiplier.
// The state encoding is fixed so that the unused code 2'd3 can be recovered explicitly.
package imul_pkg;

  localparam int unsigned IMUL_W     = 32;
  localparam int unsigned IMUL_NITER = 32;
  localparam int unsigned IMUL_CW    = $clog2(IMUL_NITER);

  typedef enum logic [1:0] {
    IMUL_IDLE = 2'd0,
    IMUL_CALC = 2'd1,
    IMUL_DONE = 2'd2
  } imul_state_e;

  function automatic logic imul_last_iter(input logic [IMUL_CW-1:0] cnt);
    return cnt == IMUL_CW'(IMUL_NITER - 1);
  endfunction

endpackage

// File: rtl/imul_seq_32b_if.sv
// Operand and product val/rdy streams of the multiplier.
// The master side produces operands and consumes products; the slave side is the unit.
interface imul_seq_32b_if;
  import imul_pkg::*;

  logic              istream_val;
  logic              istream_rdy;
  logic [IMUL_W-1:0] in0;
  logic [IMUL_W-1:0] in1;
  logic              ostream_val;
  logic              ostream_rdy;
  logic [IMUL_W-1:0] prod;

  modport master (
    output istream_val, in0, in1, ostream_rdy,
    input  istream_rdy, ostream_val, prod
  );

  modport slave (
    input  istream_val, in0, in1, ostream_rdy,
    output istream_rdy, ostream_val, prod
  );

endinterface

// File: rtl/Adder_32b_GL.sv
// 32-bit gate-level ripple adder; the multiplier's only arithmetic resource.
// The carry out of bit 31 is dropped, so sums wrap modulo 2^32.
module Adder_32b_GL (
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic        cin,
  output logic [31:0] out
);

  always_comb begin
    logic c;
    logic p;
    out = '0;
    c   = cin;
    for (int i = 0; i < 32; i++) begin
      p      = in0[i] ^ in1[i];
      out[i] = p ^ c;
      c      = (in0[i] & in1[i]) | (p & c);
    end
  end

endmodule

// File: rtl/imul_seq_32b.sv
// Iterative shift-and-add multiplier returning the low 32 bits of in0*in1.
// One adder is reused over exactly 32 iterations; there is no early exit.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   IMUL_IDLE | ready for an operand pair; prod holds the last result
//   IMUL_CALC | one add/shift iteration per cycle, 32 cycles
//   IMUL_DONE | product valid, held until the consumer takes it
module imul_seq_32b
  import imul_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  imul_seq_32b_if.slave  io
);

  imul_state_e        state_q, state_d;
  logic [IMUL_CW-1:0] count_q, count_d;
  logic [IMUL_W-1:0]  a_q, a_d;
  logic [IMUL_W-1:0]  b_q, b_d;
  logic [IMUL_W-1:0]  result_q, result_d;
  logic [IMUL_W-1:0]  sum;

  logic in_idle;
  logic in_calc;
  logic in_done;
  logic accept;
  logic result_en;

  Adder_32b_GL u_adder (
    .in0 (result_q),
    .in1 (a_q),
    .cin (1'b0),
    .out (sum)
  );

  // Control: next state, iteration counter and handshake decode.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    in_idle = 1'b0;
    in_calc = 1'b0;
    in_done = 1'b0;
    case (state_q)
      IMUL_IDLE: begin
        in_idle = 1'b1;
        if (io.istream_val) begin
          count_d = '0;
          state_d = IMUL_CALC;
        end
      end
      IMUL_CALC: begin
        in_calc = 1'b1;
        count_d = count_q + 1'b1;
        if (imul_last_iter(count_q)) begin
          state_d = IMUL_DONE;
        end
      end
      IMUL_DONE: begin
        in_done = 1'b1;
        if (io.ostream_rdy) begin
          state_d = IMUL_IDLE;
        end
      end
      default: begin
        state_d = IMUL_IDLE;
      end
    endcase
  end

  assign accept    = in_idle & io.istream_val;
  assign result_en = in_calc & b_q[0];

  // Datapath: operand shift registers and the accumulating result register.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    if (accept) begin
      a_d      = io.in0;
      b_d      = io.in1;
      result_d = '0;
    end else if (in_calc) begin
      a_d = a_q << 1;
      b_d = b_q >> 1;
      if (result_en) begin
        result_d = sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IMUL_IDLE;
      count_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign io.istream_rdy = in_idle;
  assign io.ostream_val = in_done;
  assign io.prod        = result_q;

endmodule

// File: tb/tb_imul_seq_32b.sv
// Directed and randomized checks of imul_seq_32b against a plain multiply reference.
module tb_imul_seq_32b;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] exp_q[$];
  logic [31:0] sa, sb;
  bit          have;
  int          got, sent, cyc, lat;

  imul_seq_32b_if bus ();

  imul_seq_32b dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one operation, checks latency and product, optionally stalls the output.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    logic [31:0] exp;
    int          l;
    exp = a * b;
    bus.ostream_rdy = (hold == 0);
    bus.in0 = a;
    bus.in1 = b;
    bus.istream_val = 1'b1;
    check({tag, "_irdy_before"}, 32'(bus.istream_rdy), 32'd1);
    @(negedge clk);
    bus.istream_val = 1'b0;
    l = 1;
    while (!bus.ostream_val && l < 100) begin
      @(negedge clk);
      l++;
    end
    check({tag, "_latency"}, 32'(l), 32'd33);
    check({tag, "_prod"}, bus.prod, exp);
    for (int i = 0; i < hold; i++) begin
      bus.istream_val = 1'b1;
      bus.in0 = 32'd5;
      bus.in1 = 32'd5;
      check({tag, "_hold_prod"}, bus.prod, exp);
      check({tag, "_hold_irdy"}, 32'(bus.istream_rdy), 32'd0);
      check({tag, "_hold_oval"}, 32'(bus.ostream_val), 32'd1);
      @(negedge clk);
    end
    bus.istream_val = 1'b0;
    bus.ostream_rdy = 1'b1;
    @(negedge clk);
    check({tag, "_oval_after"}, 32'(bus.ostream_val), 32'd0);
    check({tag, "_irdy_after"}, 32'(bus.istream_rdy), 32'd1);
  endtask

  initial begin
    bus.istream_val = 1'b0;
    bus.in0 = '0;
    bus.in1 = '0;
    bus.ostream_rdy = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_irdy", 32'(bus.istream_rdy), 32'd1);
    check("rst_oval", 32'(bus.ostream_val), 32'd0);
    check("rst_prod", bus.prod, 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("idle_oval", 32'(bus.ostream_val), 32'd0);
    end

    run_op("basic", 32'd7, 32'd6, 0);
    run_op("ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("msb_x2", 32'h8000_0000, 32'd2, 0);
    run_op("neg3x5", 32'hFFFF_FFFD, 32'd5, 0);
    check("neg3x5_value", bus.prod, 32'hFFFF_FFF1);
    run_op("bp", 32'd12345, 32'd678, 10);
    check("bp_value", bus.prod, 32'd8369910);
    for (int i = 0; i < 36; i++) begin
      check("bp_ignored_req", 32'(bus.ostream_val), 32'd0);
      @(negedge clk);
    end
    run_op("zero", 32'hDEAD_BEEF, 32'd0, 0);

    // Reset in the middle of a calculation.
    bus.ostream_rdy = 1'b1;
    bus.in0 = 32'd9;
    bus.in1 = 32'd9;
    bus.istream_val = 1'b1;
    @(negedge clk);
    bus.istream_val = 1'b0;
    lat = 1;
    while (lat < 15) begin
      @(negedge clk);
      lat++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_irdy", 32'(bus.istream_rdy), 32'd1);
    check("midrst_oval", 32'(bus.ostream_val), 32'd0);
    check("midrst_prod", bus.prod, 32'd0);
    run_op("after_rst", 32'd3, 32'd4, 0);

    // Random streaming with gaps on both sides.
    got = 0;
    sent = 0;
    cyc = 0;
    have = 1'b0;
    while (got < 20 && cyc < 4000) begin
      if (!have && sent < 20) begin
        sa = $urandom;
        sb = $urandom;
        have = 1'b1;
      end
      bus.istream_val = have && ($urandom_range(0, 2) != 0);
      bus.in0 = sa;
      bus.in1 = sb;
      bus.ostream_rdy = ($urandom_range(0, 2) != 0);
      if (bus.istream_val && bus.istream_rdy) begin
        exp_q.push_back(sa * sb);
        have = 1'b0;
        sent++;
      end
      if (bus.ostream_val && bus.ostream_rdy) begin
        if (exp_q.size() == 0) begin
          check("stream_extra", 32'(exp_q.size()), 32'd1);
        end else begin
          check("stream_prod", bus.prod, exp_q.pop_front());
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.istream_val = 1'b0;
    check("stream_count", 32'(got), 32'd20);
    check("stream_left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imul_seq_32b.md
# imul_seq_32b

Iterative 32-bit integer multiplier controller that time-multiplexes a single 32-bit ripple/carry-select adder over 32 cycles to form the low 32 bits of a product. It sits beside the ALU in the TinyRV1 processor datapath as the `mul` functional unit. It accepts operands over a val/rdy input stream and returns the product over a val/rdy output stream.

## Interface
- Parameters: none. Width is fixed at 32 to match the shared adder; the iteration count is fixed at 32.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `istream_val` in 1: operand pair valid.
- `istream_rdy` out 1: unit can accept an operand pair.
- `in0` in 32: multiplicand (a).
- `in1` in 32: multiplier (b).
- `ostream_val` out 1: product valid.
- `ostream_rdy` in 1: consumer accepts the product.
- `prod` out 32: low 32 bits of `in0*in1` (signed and unsigned low halves are identical).

## Operation
- State machine states: IDLE, CALC, DONE. Registers: `a_reg[31:0]`, `b_reg[31:0]`, `result_reg[31:0]`, `count[4:0]`.
- IDLE:
  - `istream_rdy=1`, `ostream_val=0`.
  - On `istream_val`: `a_reg<=in0`, `b_reg<=in1`, `result_reg<=0`, `count<=0`, go to CALC.
- CALC:
  - `istream_rdy=0`, `ostream_val=0`.
  - Each cycle: if `b_reg[0]`, then `result_reg<=sum` (adder inputs are `result_reg` and `a_reg`, cin=0); otherwise hold.
  - Each cycle: `a_reg<=a_reg<<1`, `b_reg<=b_reg>>1` (logical), `count<=count+1`.
  - When `count==31`, perform the final iteration and go to DONE.
  - The adder carry-out is discarded; sums wrap modulo 2^32.
- DONE:
  - `ostream_val=1`, `prod=result_reg`, `istream_rdy=0`.
  - On `ostream_rdy`, go to IDLE. Otherwise hold, keeping `prod` stable while `ostream_val` is high.
- No early termination: every operation takes exactly 32 CALC cycles, even when `b_reg` reaches 0.
- `prod` is driven from `result_reg` in all states. It is valid only when `ostream_val=1`.
- `istream_rdy` and `ostream_val` are decoded from state only, with no combinational path from `istream_val` or `ostream_rdy`.

## Timing
- Reset values after `rst` is high at a rising edge:
  - state=IDLE, `istream_rdy=1`, `ostream_val=0`.
  - `result_reg=0`, hence `prod=0`.
  - `count=0`, `a_reg=0`, `b_reg=0`.
- Reset has priority in every state. Asserting `rst` mid-CALC or in DONE abandons the operation, and no stale product is emitted.
- Input handshake: accept at edge T when `istream_val & istream_rdy`. CALC occupies cycles T+1 … T+32, and `ostream_val` rises in cycle T+33.
- Latency is 33 cycles from acceptance to first `ostream_val`.
- Output handshake: the transfer completes at the edge where `ostream_val & ostream_rdy`. The unit is in IDLE the next cycle, so the earliest next accept is one cycle after the output transfer.
- Back-to-back throughput is therefore one product per 34 cycles when `ostream_rdy` is held high.
- `ostream_rdy` asserted early (before DONE) has no effect.
- `istream_val` while not in IDLE is ignored. The producer must hold operands until it sees `istream_rdy`.
- The adder is purely combinational; its critical path plus register setup must close in one cycle.

## Structure
- Shared package `imul_pkg`:
  - State encoding constants `IMUL_IDLE=2'd0`, `IMUL_CALC=2'd1`, `IMUL_DONE=2'd2`. Encoding 2'd3 is illegal and recovers to IDLE.
  - `IMUL_NITER=32`.
- One natural sub-module: the team's existing 32-bit gate-level adder `Adder_32b_GL`, instantiated once as the sole arithmetic resource.
- Remaining logic is split into control (FSM, counter, handshake decode) and datapath (shift registers, result register with load-enable = CALC & `b_reg[0]`).

## Test plan
- Reset then idle:
  - Stimulus: `rst=1` for 2 cycles, then release.
  - Required: `istream_rdy=1`, `ostream_val=0`, `prod=0`; no `ostream_val` for 40 cycles with `istream_val=0`.
- Basic product:
  - Stimulus: `in0=7`, `in1=6`, accepted at cycle T, with `ostream_rdy=1`.
  - Required: `ostream_val` first high at T+33 with `prod=42`; `istream_rdy=1` again at T+34.
- Wrap and signed:
  - `0xFFFFFFFF*0xFFFFFFFF` -> `prod=0x00000001`.
  - `0x80000000*2` -> `prod=0`.
  - `-3*5` (`0xFFFFFFFD*5`) -> `prod=0xFFFFFFF1`.
- Output backpressure:
  - Stimulus: `12345*678`, with `ostream_rdy=0` for 10 cycles after `ostream_val` rises.
  - Required: `prod=8369910` stable throughout, `istream_rdy=0`, and a new `istream_val` in that window is not accepted.
- Reset mid-operation:
  - Stimulus: accept `9*9`, assert `rst` at T+15.
  - Required: next cycle state=IDLE, `ostream_val=0`, `prod=0`; a following `3*4` yields 12 at 33 cycles after its accept.
- Streaming:
  - Stimulus: 20 random operand pairs with random `istream_val`/`ostream_rdy` gaps.
  - Required: outputs in order, each equal to `(in0*in1) mod 2^32`, none dropped or duplicated.
